fpu_add_arbiter: RTL and testbench

FPU_ADD_ARBITER -- requirements
Module: fpu_add_arbiter

---
 rtl/fpu_add_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fpu_add_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: two requesters share one single-precision adder through an IDLE/EXEC/RESP FSM.
// Ports: clk, rst_n (async, active low); req_valid/req_ready/req_a/req_b/req_sub carry per-port
// requests (port k in lane k); rsp_valid/rsp_ready/rsp_s/rsp_flags return the registered result
// {zero, nan, overflow, underflow}; busy is high outside IDLE.
// Define FPU_ARB_RR_EN for round-robin contention; the default build uses fixed priority to port 0.
module fpu_add_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [1:0]  req_sub,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_s,
    output logic [3:0]  rsp_flags,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state, state_nx;
    logic        gnt, pick, take, op_sub, f_zero, f_nan, f_ovf, f_unf;
    logic [31:0] op_a, op_b, sum;

`ifdef FPU_ARB_RR_EN
    logic last;
    assign pick = &req_valid ? ~last : ~req_valid[0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last <= 1'b1;
        else if (take) last <= pick;
`else
    assign pick = ~req_valid[0];
`endif

    // rst_n gates req_ready so it drops immediately, not only once state settles
    always_comb begin
        state_nx  = state;
        take      = 1'b0;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state)
            IDLE: if (rst_n && |req_valid) begin
                take      = 1'b1;
                req_ready = pick ? 2'b10 : 2'b01;
                state_nx  = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: begin
                rsp_valid = gnt ? 2'b10 : 2'b01;
                state_nx  = rsp_ready[gnt] ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_sub    <= 1'b0;
            rsp_s     <= '0;
            rsp_flags <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                gnt    <= pick;
                op_a   <= pick ? req_a[63:32] : req_a[31:0];
                op_b   <= pick ? req_b[63:32] : req_b[31:0];
                op_sub <= pick ? req_sub[1] : req_sub[0];
            end
            if (state == EXEC) begin
                rsp_s     <= sum;
                rsp_flags <= {f_zero, f_nan, f_ovf, f_unf};
            end
        end
    end

    FPU_adder_32bit u_add (
        .a(op_a), .b(op_b), .sub(op_sub), .s(sum),
        .zero(f_zero), .nan(f_nan), .overflow(f_ovf), .underflow(f_unf)
    );
endmodule

// FPU_adder_32bit: combinational IEEE-754 single add/sub, round to nearest even.
// Ports: a, b operands; sub selects a-b; s result; zero/nan/overflow/underflow status.
module FPU_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] s,
    output logic        zero,
    output logic        nan,
    output logic        overflow,
    output logic        underflow
);
    logic        sb, swap, sx, sy, sgn, inc, a_nan, b_nan, a_inf, b_inf;
    logic [30:0] ox, oy;
    logic [8:0]  ex, ey, d, e, fe;
    logic [23:0] mx, my;
    logic [26:0] t, ay;
    logic [27:0] sum, n;
    logic [24:0] r;
    always_comb begin
        sb    = b[31] ^ sub;
        a_nan = &a[30:23] && |a[22:0];
        b_nan = &b[30:23] && |b[22:0];
        a_inf = &a[30:23] && ~|a[22:0];
        b_inf = &b[30:23] && ~|b[22:0];
        // x is the larger magnitude so the aligned difference never goes negative
        swap = b[30:0] > a[30:0];
        ox   = swap ? b[30:0] : a[30:0];
        oy   = swap ? a[30:0] : b[30:0];
        sx   = swap ? sb : a[31];
        sy   = swap ? a[31] : sb;
        ex   = {1'b0, (ox[30:23] == 8'd0 ? 8'd1 : ox[30:23])};
        ey   = {1'b0, (oy[30:23] == 8'd0 ? 8'd1 : oy[30:23])};
        mx   = {|ox[30:23], ox[22:0]};
        my   = {|oy[30:23], oy[22:0]};
        d    = ex - ey;
        // three extra bits (guard, round, sticky); everything shifted out folds into sticky
        t     = {my, 3'b000};
        ay    = t >> d;
        ay[0] = ay[0] | (|(t & ~({27{1'b1}} << d)));
        sum   = (sx == sy) ? {1'b0, mx, 3'b000} + {1'b0, ay} : {1'b0, mx, 3'b000} - {1'b0, ay};
        n     = sum;
        e     = ex;
        if (n[27]) begin
            n = {1'b0, n[27:2], |n[1:0]};
            e = e + 9'd1;
        end
        // normalise left, stopping at the subnormal exponent
        for (int i = 0; i < 26; i++)
            if (!n[26] && e > 9'd1) begin
                n = n << 1;
                e = e - 9'd1;
            end
        inc = n[2] & (n[3] | n[1] | n[0]);
        r   = {1'b0, n[26:3]} + {24'd0, inc};
        if (r[24]) begin
            r = {1'b0, r[24:1]};
            e = e + 9'd1;
        end
        fe        = r[23] ? e : 9'd0;
        sgn       = (sum == 28'd0) ? (sx & sy) : sx;
        nan       = a_nan | b_nan | (a_inf & b_inf & (a[31] != sb));
        overflow  = 1'b0;
        underflow = 1'b0;
        zero      = 1'b0;
        s         = 32'h7FC0_0000;
        if (!nan && (a_inf || b_inf))
            s = a_inf ? a : {sb, b[30:0]};
        else if (!nan) begin
            overflow  = fe >= 9'd255;
            s         = overflow ? {sgn, 8'hFF, 23'd0} : {sgn, fe[7:0], r[22:0]};
            zero      = s[30:0] == 31'd0;
            underflow = fe == 9'd0 && !zero;
        end
    end
endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb_fpu_add_arbiter: directed self-checking bench for fpu_add_arbiter.
module tb_fpu_add_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, busy;
    logic [1:0]  req_valid = '0, req_sub = '0, rsp_ready = '0, req_ready, rsp_valid;
    logic [63:0] req_a = '0, req_b = '0;
    logic [31:0] rsp_s;
    logic [3:0]  rsp_flags;
    int          errors = 0, checks = 0;

    fpu_add_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " req_ready"}, {30'd0, req_ready}, 0);
        chk({tag, " rsp_valid"}, {30'd0, rsp_valid}, 0);
        chk({tag, " rsp_s"}, rsp_s, 0);
        chk({tag, " rsp_flags"}, {28'd0, rsp_flags}, 0);
        chk({tag, " busy"}, {31'd0, busy}, 0);
    endtask

    // one full transaction with rsp_ready=11: grant, EXEC, RESP, back to IDLE
    task automatic serve(input string tag, input logic [1:0] port, input logic [31:0] exp_s);
        chk({tag, " grant"}, {30'd0, req_ready}, {30'd0, port});
        tick;
        chk({tag, " exec"}, {29'd0, busy, rsp_valid}, 32'h4);
        tick;
        chk({tag, " rsp_valid"}, {30'd0, rsp_valid}, {30'd0, port});
        chk({tag, " rsp_s"}, rsp_s, exp_s);
        chk({tag, " flags"}, {28'd0, rsp_flags}, 0);
        tick;
        chk({tag, " idle"}, {31'd0, busy}, 0);
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        tick;
        tick;
        rst_n = 1'b1;
        #1;
        chk("post-reset idle", {29'd0, busy, rsp_valid}, 0);

        // 1.0 + 1.0 on port 0, held one extra cycle by rsp_ready=0
        req_a = {32'h0, 32'h3F80_0000};
        req_b = {32'h0, 32'h3F80_0000};
        req_sub = 2'b00;
        req_valid = 2'b01;
        #1;
        chk("basic grant", {30'd0, req_ready}, 1);
        tick;
        req_valid = 2'b00;
        chk("basic exec", {29'd0, busy, rsp_valid}, 32'h4);
        tick;
        chk("basic rsp_valid", {30'd0, rsp_valid}, 1);
        chk("basic rsp_s", rsp_s, 32'h4000_0000);
        chk("basic flags", {28'd0, rsp_flags}, 0);
        tick;
        chk("basic hold", {30'd0, rsp_valid}, 1);
        rsp_ready = 2'b01;
        tick;
        chk("basic done", {29'd0, busy, rsp_valid}, 0);

        // contention: p0 2.5+3.75, p1 3.75-2.5
        rsp_ready = 2'b11;
        req_a = {32'h4070_0000, 32'h4020_0000};
        req_b = {32'h4020_0000, 32'h4070_0000};
        req_sub = 2'b10;
        req_valid = 2'b11;
        #1;
        serve("c1", 2'b01, 32'h40C8_0000);
`ifdef FPU_ARB_RR_EN
        serve("c2", 2'b10, 32'h3FA0_0000);
        serve("c3", 2'b01, 32'h40C8_0000);
`else
        serve("c2", 2'b01, 32'h40C8_0000);
        serve("c3", 2'b01, 32'h40C8_0000);
        req_valid = 2'b10;
        #1;
        serve("c4", 2'b10, 32'h3FA0_0000);
`endif
        req_valid = 2'b00;

        // backpressure: inf - inf on p1, held five cycles
        rsp_ready = 2'b00;
        req_a = {32'h7F80_0000, 32'h3F80_0000};
        req_b = {32'h7F80_0000, 32'h3F80_0000};
        req_sub = 2'b10;
        req_valid = 2'b10;
        #1;
        chk("bp grant", {30'd0, req_ready}, 2);
        tick;
        req_valid = 2'b01;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid", {30'd0, rsp_valid}, 2);
            chk("bp rsp_s", rsp_s, 32'h7FC0_0000);
            chk("bp flags", {28'd0, rsp_flags}, 32'h4);
            chk("bp req_ready", {30'd0, req_ready}, 0);
            chk("bp busy", {31'd0, busy}, 1);
            if (i == 4) req_valid = 2'b00;
            tick;
        end
        chk("bp still held", {30'd0, rsp_valid}, 2);
        rsp_ready = 2'b10;
        tick;
        chk("bp released", {29'd0, busy, rsp_valid}, 0);

        // overflow on p0, p1 rsp_ready pulses ignored
        rsp_ready = 2'b00;
        req_a = {32'h0, 32'h7F7F_FFFF};
        req_b = {32'h0, 32'h7F7F_FFFF};
        req_sub = 2'b00;
        req_valid = 2'b01;
        #1;
        chk("ovf grant", {30'd0, req_ready}, 1);
        tick;
        req_valid = 2'b00;
        tick;
        chk("ovf rsp_valid", {30'd0, rsp_valid}, 1);
        chk("ovf rsp_s", rsp_s, 32'h7F80_0000);
        chk("ovf flags", {28'd0, rsp_flags}, 32'h2);
        rsp_ready = 2'b10;
        tick;
        chk("ovf ignore p1 a", {29'd0, busy, rsp_valid}, 32'h5);
        rsp_ready = 2'b00;
        tick;
        rsp_ready = 2'b10;
        tick;
        chk("ovf ignore p1 b", {29'd0, busy, rsp_valid}, 32'h5);
        chk("ovf stable", rsp_s, 32'h7F80_0000);
        rsp_ready = 2'b01;
        tick;
        chk("ovf done", {29'd0, busy, rsp_valid}, 0);

        // reset during EXEC
        req_a = {32'h4070_0000, 32'h3F80_0000};
        req_b = {32'h4020_0000, 32'h3F80_0000};
        req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        chk("mid exec busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid reset");
        tick;
        tick;
        #2;
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("after reset quiet", {29'd0, busy, rsp_valid}, 0);
        end
        req_a = {32'h4070_0000, 32'h4020_0000};
        req_b = {32'h4020_0000, 32'h4070_0000};
        req_sub = 2'b10;
        req_valid = 2'b11;
        #1;
        serve("post-reset contention", 2'b01, 32'h40C8_0000);
        req_valid = 2'b00;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
